// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and frame timing helpers
// used by uart_tx, uart_rx and uart_tx_arb.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  function automatic int bit_clks(input int clk_fre, input int baud);
    return (clk_fre * 1000000) / baud;
  endfunction

  // start + data + parity + stop bits, plus idle guard after the stop bit
  function automatic int frame_clks(input int dw, input int par, input int stop,
                                    input int bclks, input int guard);
    return (1 + dw + par + stop) * bclks + guard;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin search: first set bit of eligible at or above ptr,
// wrapping at N_REQ.
module uart_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDW-1:0]   ptr,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  always_comb begin
    int k;
    found = 1'b0;
    idx   = '0;
    k     = 0;
    // walk offsets high to low so the closest one to ptr is written last
    for (int off = N_REQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % N_REQ;
      if (eligible[k]) begin
        found = 1'b1;
        idx   = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte sources; frame
// occupancy is timed locally since uart_tx has no ready output.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ON  = 1,
  parameter int STOP_BITS  = 1,
  parameter int GUARD_CLKS = 16,
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                        i_clk_sys,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [N_REQ-1:0]            i_chan_en,
  output logic [N_REQ-1:0]            o_req_ack,
  output logic [DATA_WIDTH-1:0]       o_data_tx,
  output logic                        o_data_valid,
  output logic [IDW-1:0]              o_grant_id,
  output logic                        o_busy
);

  localparam int BIT_CLKS   = bit_clks(CLK_FRE, BAUD_RATE);
  localparam int FRAME_CLKS = frame_clks(DATA_WIDTH, PARITY_ON, STOP_BITS, BIT_CLKS, GUARD_CLKS);
  localparam int CW         = $clog2(FRAME_CLKS + 1);

  arb_state_e      state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;
  logic [N_REQ-1:0] eligible;
  logic            pick_found;
  logic [IDW-1:0]  pick_idx;

  assign eligible = i_req_valid & i_chan_en;

  uart_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_found) state_nx = SEND;
      SEND:    state_nx = WAIT;
      WAIT:    if (cnt == CW'(1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Data and winner are captured in the IDLE decision cycle; later changes
  // to requests or i_chan_en cannot disturb the frame in flight.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      ptr        <= '0;
      cnt        <= '0;
      o_data_tx  <= '0;
      o_grant_id <= '0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          o_data_tx  <= i_req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
          o_grant_id <= pick_idx;
        end
        SEND: begin
          cnt <= CW'(FRAME_CLKS);
          ptr <= (o_grant_id == IDW'(N_REQ - 1)) ? '0 : o_grant_id + 1'b1;
        end
        WAIT:    cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_data_valid = (state == SEND);
  assign o_busy       = (state != IDLE);
  assign o_req_ack    = (state == SEND) ? (N_REQ'(1) << o_grant_id) : '0;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb against a cycle-level behavioural model
// (pending requests, next-decision time, arithmetic round-robin pointer).
module tb_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int F  = (1 + 8 + 1 + 1) * (1 * 1000000 / 250000) + 16; // 60

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      chan_en;
  logic [N-1:0]      req_ack;
  logic [DW-1:0]     data_tx;
  logic              data_valid;
  logic [1:0]        grant_id;
  logic              busy;

  uart_tx_arb #(
    .N_REQ(N), .DATA_WIDTH(DW), .CLK_FRE(1), .BAUD_RATE(250000),
    .PARITY_ON(1), .STOP_BITS(1), .GUARD_CLKS(16)
  ) dut (
    .i_clk_sys    (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .i_chan_en    (chan_en),
    .o_req_ack    (req_ack),
    .o_data_tx    (data_tx),
    .o_data_valid (data_valid),
    .o_grant_id   (grant_id),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  // requester side
  logic [N-1:0]  req_v;
  logic [DW-1:0] req_d [N];
  logic [N-1:0]  act;
  int            prob;
  int            dmode;
  logic [DW-1:0] seq;

  // reference model state
  int            next_dec, last_pulse, ptr_m;
  bit            have_pulse;
  logic [DW-1:0] exp_data;
  logic [1:0]    exp_gid;
  logic [N-1:0]  exp_ack;
  logic          exp_valid, exp_busy;

  // observed pulses
  int            dpulse, prev_dpulse, npulse;
  int            gq[$];
  logic [DW-1:0] dq[$];
  logic [N-1:0]  ack_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h edge=%0d", tag, got, want, e);
    end
  endtask

  task automatic drive();
    req_valid = req_v;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = req_d[k];
  endtask

  task automatic model_reset();
    next_dec   = e + 1;
    ptr_m      = 0;
    have_pulse = 1'b0;
    last_pulse = 0;
    exp_data   = '0;
    exp_gid    = '0;
  endtask

  task automatic step();
    logic [N-1:0] elig;
    @(posedge clk);
    e++;
    elig      = req_v & chan_en;
    exp_valid = 1'b0;
    exp_ack   = '0;
    if (e >= next_dec && elig != 0) begin
      int w;
      w = -1;
      for (int off = 0; off < N; off++)
        if (w < 0 && elig[(ptr_m + off) % N]) w = (ptr_m + off) % N;
      exp_valid  = 1'b1;
      exp_ack[w] = 1'b1;
      exp_data   = req_d[w];
      exp_gid    = 2'(w);
      ptr_m      = (w + 1) % N;
      last_pulse = e;
      have_pulse = 1'b1;
      next_dec   = e + F + 2;
    end
    exp_busy = have_pulse && (e - last_pulse <= F);
    #1;
    chk("valid", 32'(data_valid), 32'(exp_valid));
    chk("ack",   32'(req_ack),    32'(exp_ack));
    chk("data",  32'(data_tx),    32'(exp_data));
    chk("gid",   32'(grant_id),   32'(exp_gid));
    chk("busy",  32'(busy),       32'(exp_busy));
    ack_acc |= req_ack;
    if (data_valid) begin
      prev_dpulse = dpulse;
      dpulse      = e;
      npulse++;
      gq.push_back(int'(grant_id));
      dq.push_back(data_tx);
    end
    // requesters drop valid after their ack and may re-request at once
    for (int k = 0; k < N; k++) begin
      if (exp_ack[k]) req_v[k] = 1'b0;
      if (!req_v[k] && act[k] && $urandom_range(99) < prob) begin
        req_v[k] = 1'b1;
        case (dmode)
          1:       req_d[k] = DW'(8'h10 + k);
          2:       begin req_d[k] = seq; seq = seq + 1'b1; end
          default: req_d[k] = DW'($urandom);
        endcase
      end
    end
    drive();
  endtask

  task automatic wait_pulses(input int n);
    int target, budget;
    target = npulse + n;
    budget = n * (F + 10) + 20;
    while (npulse < target && budget > 0) begin
      step();
      budget--;
    end
    if (npulse < target) chk("pulse_timeout", 32'(npulse), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    gq.delete();
    dq.delete();
    ack_acc = '0;
  endtask

  initial begin
    rst = 1'b1; chan_en = '1; req_v = '0; act = '0; prob = 0; dmode = 0; seq = 8'hA1;
    for (int k = 0; k < N; k++) req_d[k] = '0;
    dpulse = 0; prev_dpulse = 0; npulse = 0; ack_acc = '0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(data_valid), 0);
    chk("rst_ack",   32'(req_ack),    0);
    chk("rst_data",  32'(data_tx),    0);
    chk("rst_gid",   32'(grant_id),   0);
    chk("rst_busy",  32'(busy),       0);
    #1 rst = 1'b0;
    model_reset();

    // single requester stream: req2 sends A1, A2, A3
    act = 4'b0100; prob = 100; dmode = 2;
    wait_pulses(1);
    wait_pulses(1);
    chk("single_gap1", 32'(dpulse - prev_dpulse), 32'(F + 2));
    wait_pulses(1);
    chk("single_gap2", 32'(dpulse - prev_dpulse), 32'(F + 2));
    chk("single_d0", 32'(dq[0]), 32'h a1);
    chk("single_d1", 32'(dq[1]), 32'h a2);
    chk("single_d2", 32'(dq[2]), 32'h a3);
    for (int i = 0; i < 3; i++) chk("single_gid", 32'(gq[i]), 2);

    // round robin with all four held valid
    act = '0; req_v = '0; drive();
    do_reset();
    for (int k = 0; k < N; k++) req_d[k] = DW'(8'h10 + k);
    req_v = '1; act = '1; prob = 100; dmode = 1; drive();
    wait_pulses(5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", 32'(gq[i]), 32'(i % N));
      chk("rr_data",  32'(dq[i]), 32'(8'h10 + (i % N)));
    end

    // masked channels 0 and 2
    act = '0; req_v = '0; drive();
    do_reset();
    chan_en = 4'b1010; req_v = '1; act = '1; dmode = 0; drive();
    wait_pulses(4);
    for (int i = 0; i < 4; i++) chk("mask_order", 32'(gq[i]), (i % 2) ? 3 : 1);
    chk("mask_never", 32'(ack_acc & 4'b0101), 0);

    // late request arriving during another frame's WAIT
    act = '0; req_v = '0; drive();
    do_reset();
    chan_en = '1; req_v = 4'b0001; req_d[0] = 8'h20; drive();
    wait_pulses(1);
    repeat (10) step();
    req_v[1] = 1'b1; req_d[1] = 8'h21; drive();
    wait_pulses(1);
    chk("late_gap", 32'(dpulse - prev_dpulse), 32'(F + 2));
    chk("late_gid", 32'(gq[1]), 1);
    chk("late_data", 32'(dq[1]), 32'h21);

    // randomized traffic with a drifting enable mask
    act = '1; prob = 30; dmode = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 0) chan_en = N'($urandom);
      step();
    end

    // reset in the middle of a frame, then a single request from req0
    chan_en = '1;
    begin
      int budget;
      budget = 3 * F;
      while (!(busy && !data_valid) && budget > 0) begin step(); budget--; end
      chk("midwait_reached", 32'(busy && !data_valid), 1);
    end
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(data_valid), 0);
    chk("midrst_ack",   32'(req_ack),    0);
    chk("midrst_data",  32'(data_tx),    0);
    chk("midrst_gid",   32'(grant_id),   0);
    chk("midrst_busy",  32'(busy),       0);
    act = '0; req_v = 4'b0001; req_d[0] = 8'h55; drive();
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    step();
    chk("post_rst_valid", 32'(data_valid), 1);
    chk("post_rst_data",  32'(data_tx),    32'h55);
    chk("post_rst_ack",   32'(req_ack),    32'b0001);
    repeat (F + 5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one uart_tx instance among N_REQ byte sources (e.g. loopback echo, status reporter, debug console).
- uart_tx has no busy/ready output, so this block times each frame itself from the UART parameters. It issues exactly one i_data_valid pulse per frame and never overlaps frames.
- Sits between the requesters and uart_tx.
  - o_data_tx drives uart_tx.i_data_tx.
  - o_data_valid drives uart_tx.i_data_valid.

Parameters:
N_REQ, 4, number of requesters (≥2)
DATA_WIDTH, 8, data bits per frame; must match uart_tx
CLK_FRE, 50, system clock in MHz; must match uart_tx
BAUD_RATE, 9600, baud; must match uart_tx
PARITY_ON, 1, 1 = parity bit present in frame
STOP_BITS, 1, stop bits per frame (1 or 2)
GUARD_CLKS, 16, extra idle clocks after each frame

Ports:
i_clk_sys  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_req_valid  in  N_REQ  per-requester request; held until acked
i_req_data  in  N_REQ*DATA_WIDTH  requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
i_chan_en  in  N_REQ  per-requester enable mask (quasi-static config)
o_req_ack  out  N_REQ  one-cycle accept pulse, one-hot
o_data_tx  out  DATA_WIDTH  byte to uart_tx
o_data_valid  out  1  one-cycle launch pulse to uart_tx
o_grant_id  out  clog2(N_REQ)  index of last granted requester
o_busy  out  1  high while a frame is in flight (SEND or WAIT)

Behaviour:
- Derived constants:
  - BIT_CLKS = CLK_FRE*1_000_000/BAUD_RATE (integer division)
  - FRAME_CLKS = (1+DATA_WIDTH+PARITY_ON+STOP_BITS)*BIT_CLKS + GUARD_CLKS
  - Counter width = clog2(FRAME_CLKS+1)
- Reset (async on i_rst high): state IDLE, rr pointer 0, counter 0. All outputs 0, including o_data_tx and o_grant_id. Reset mid-frame aborts tracking; no ack or valid is issued during reset.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - Eligible set = i_req_valid & i_chan_en.
  - If non-empty: winner = first eligible index searching upward from rr pointer, wrapping at N_REQ. Register i_req_data[winner] into o_data_tx and winner into o_grant_id, then go to SEND.
  - If empty: stay in IDLE, all pulses 0.
- SEND (exactly 1 cycle): o_data_valid=1, o_req_ack[winner]=1, o_busy=1. Load counter with FRAME_CLKS, set rr pointer = (winner+1) mod N_REQ, go to WAIT.
- WAIT: o_busy=1; counter decrements each cycle. When counter==1, next state is IDLE. WAIT lasts exactly FRAME_CLKS cycles.
- Latency: request seen in IDLE at cycle t gives o_data_valid/ack at t+1. Under continuous demand, o_data_valid pulses are exactly FRAME_CLKS+2 cycles apart.
- Handshake:
  - A requester keeps valid and data stable until it sees ack, and may drop valid the cycle after ack.
  - The data transmitted is the value sampled in the IDLE decision cycle.
  - Requests are ignored in SEND and WAIT.
- o_data_tx and o_grant_id hold their last value between frames.
- i_chan_en:
  - A disabled channel is never granted, even if valid.
  - Changing i_chan_en during SEND/WAIT does not affect the frame in flight.
- Single eligible requester: it is granted every frame regardless of pointer position.
- Pointer wraps from N_REQ-1 to 0.
- o_req_ack is never multi-hot; o_data_valid and the ack always pulse together.

Decomposition:
- Package uart_pkg holds:
  - state enum arb_state_e {IDLE, SEND, WAIT}
  - functions bit_clks(clk_fre, baud) and frame_clks(dw, par, stop, bit_clks, guard), shared with uart_tx/uart_rx
- Sub-module uart_rr_pick: combinational round-robin search.
  - Inputs: eligible vector, pointer.
  - Outputs: found, index.

Test Plan (override CLK_FRE=1, BAUD_RATE=250000 → BIT_CLKS=4; DW=8, PARITY_ON=1, STOP_BITS=1, GUARD_CLKS=16 → FRAME_CLKS=60):
1. Reset: assert i_rst mid-WAIT → all outputs 0 immediately. After release with req0=0x55, valid pulses 1 cycle later with o_data_tx=0x55, ack=4'b0001.
2. Single requester: req2 streams 0xA1, 0xA2, 0xA3 → three o_data_valid pulses exactly 62 cycles apart, each with ack[2], data in order, o_grant_id=2.
3. Round robin: all 4 valid and held, data 0x10..0x13 → grant order 0,1,2,3,0; ack one-hot each time; pointer wraps.
4. Mask: i_chan_en=4'b1010, all valid → only 1,3,1,3 granted; req0/req2 never acked.
5. Late request: req1 asserts during WAIT of req0's frame → no ack until WAIT ends; granted exactly at FRAME_CLKS+2 after req0's pulse.
6. Uart_tx integration (default params, 8O1): two requesters send 0x3C and 0xC3 → serial line shows both complete frames, odd parity correct, no overlap, ≥16 idle clocks between stop bit and next start bit.
